// File: rtl/uart_mem_arbiter.sv
// Shares the UART subsystem's single-port 1024x32 memory between a CPU master (port 0) and the UART buffer engine (port 1).
// Grant is combinational, so an access reaches the memory in the same cycle; read data returns one cycle after the accept.
// A loser, a master locked out, or any master during mem_reset_req sees waitrequest. UART_MEM_ARB_FIXED_PRIO_EN gives port 1 fixed priority.
module uart_mem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic                m0_lock,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic                m1_lock,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   input  logic                mem_reset_req,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int BE_W = DATA_W / 8;

   logic                req0, req1;
   logic                last_grant;
   logic                lock_vld, lock_own;
   logic [3:0]          idle_cnt;
   logic                rd_pend, rd_tag;
   logic                gnt_vld, gnt_sel;
   logic                sel_wr, sel_lock, owner_idle;
   logic [ADDR_W-1:0]   sel_addr, addr_q;
   logic [BE_W-1:0]     sel_be, be_q;
   logic [DATA_W-1:0]   sel_wd, wd_q;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_sel = 1'b0;
      if (reset_n && !mem_reset_req) begin
         if (lock_vld) begin
            gnt_vld = lock_own ? req1 : req0;
            gnt_sel = lock_own;
         end else if (req0 && req1) begin
            gnt_vld = 1'b1;
`ifdef UART_MEM_ARB_FIXED_PRIO_EN
            gnt_sel = 1'b1;
`else
            gnt_sel = ~last_grant;
`endif
         end else if (req0 || req1) begin
            gnt_vld = 1'b1;
            gnt_sel = req1;
         end
      end
   end

   assign sel_wr   = gnt_sel ? m1_write      : m0_write;
   assign sel_lock = gnt_sel ? m1_lock       : m0_lock;
   assign sel_addr = gnt_sel ? m1_address    : m0_address;
   assign sel_be   = gnt_sel ? m1_byteenable : m0_byteenable;
   assign sel_wd   = gnt_sel ? m1_writedata  : m0_writedata;

   // Only the lock owner's silence counts towards the lock timeout.
   assign owner_idle = lock_vld & ~(lock_own ? req1 : req0);

   assign m0_waitrequest   = ~(gnt_vld & ~gnt_sel);
   assign m1_waitrequest   = ~(gnt_vld &  gnt_sel);
   assign mem_chipselect   = gnt_vld;
   assign mem_write        = gnt_vld & sel_wr;
   assign mem_address      = gnt_vld ? sel_addr : addr_q;
   assign mem_byteenable   = gnt_vld ? sel_be   : be_q;
   assign mem_writedata    = gnt_vld ? sel_wd   : wd_q;
   assign mem_clken        = reset_n & ~mem_reset_req;
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = reset_n & rd_pend & ~rd_tag;
   assign m1_readdatavalid = reset_n & rd_pend &  rd_tag;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
         lock_vld   <= 1'b0;
         lock_own   <= 1'b0;
         idle_cnt   <= 4'd0;
         rd_pend    <= 1'b0;
         rd_tag     <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wd_q       <= '0;
      end else begin
         // Write wins over a simultaneous read, so only pure reads return data.
         rd_pend <= gnt_vld & ~sel_wr;
         rd_tag  <= gnt_sel;
         if (gnt_vld) begin
            last_grant <= gnt_sel;
            lock_vld   <= sel_lock;
            lock_own   <= gnt_sel;
            idle_cnt   <= 4'd0;
            addr_q     <= sel_addr;
            be_q       <= sel_be;
            wd_q       <= sel_wd;
         end else if (owner_idle) begin
            if (idle_cnt == 4'd15) begin
               lock_vld <= 1'b0;
               idle_cnt <= 4'd0;
            end else begin
               idle_cnt <= idle_cnt + 4'd1;
            end
         end else if (lock_vld) begin
            idle_cnt <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench for uart_mem_arbiter: a behavioural 1024x32 memory, per-master expected-read queues
// filled by the stimulus, and a negedge monitor that pops and compares on every readdatavalid.
module tb_uart_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        mem_reset_req;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_readdata;

   int vectors = 0;
   int errors  = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] mem [0:1023];

`ifdef UART_MEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_reset_req(mem_reset_req), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
      .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   // Single-port RAM with registered address: q follows a read one edge later and holds while gated.
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
      mem_readdata = 32'h0;
   end
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= mem[mem_address];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m0_readdatavalid && m1_readdatavalid) chk("rdv_both", 32'd1, 32'd0);
      if (m0_readdatavalid) begin
         if (q0.size() == 0) chk("m0_rdv_unexpected", 32'd1, 32'd0);
         else chk("m0_readdata", m0_readdata, q0.pop_front());
      end
      if (m1_readdatavalid) begin
         if (q1.size() == 0) chk("m1_rdv_unexpected", 32'd1, 32'd0);
         else chk("m1_readdata", m1_readdata, q1.pop_front());
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic m0_set(input logic rd, input logic wr, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] d, input logic lk);
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d; m0_lock = lk;
   endtask

   task automatic m1_set(input logic rd, input logic wr, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] d, input logic lk);
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d; m1_lock = lk;
   endtask

   task automatic idle_all();
      m0_set(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
      m1_set(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle_all();
      next();
      next();
      reset_n = 1'b1;
   endtask

   initial begin
      logic w;
      reset_n = 1'b0;
      mem_reset_req = 1'b0;
      idle_all();
      m0_set(1'b1, 1'b0, 10'h005, 4'hF, 32'h0, 1'b0);
      @(negedge clk);
      chk("rst_m0_wait", m0_waitrequest, 1);
      chk("rst_m0_rdv", m0_readdatavalid, 0);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_write", mem_write, 0);
      chk("rst_clken", mem_clken, 0);
      next();
      next();

      // Single write then read-back of the same word.
      reset_n = 1'b1;
      m0_set(1'b0, 1'b1, 10'h005, 4'hF, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      chk("wr_m0_wait", m0_waitrequest, 0);
      chk("wr_cs", mem_chipselect, 1);
      chk("wr_write", mem_write, 1);
      chk("wr_clken", mem_clken, 1);
      chk("wr_addr", mem_address, 10'h005);
      next();
      m0_set(1'b1, 1'b0, 10'h005, 4'hF, 32'h0, 1'b0);
      q0.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      chk("rd_m0_wait", m0_waitrequest, 0);
      chk("rd_write", mem_write, 0);
      next();
      idle_all();
      @(negedge clk);
      chk("rd_m0_rdv", m0_readdatavalid, 1);
      chk("rd_m1_rdv", m1_readdatavalid, 0);
      chk("idle_cs", mem_chipselect, 0);
      chk("idle_addr_hold", mem_address, 10'h005);
      next();

      // Contention from reset: round-robin starts at m0, fixed priority always m1.
      do_reset();
      m0_set(1'b1, 1'b0, 10'h010, 4'hF, 32'h0, 1'b0);
      m1_set(1'b1, 1'b0, 10'h020, 4'hF, 32'h0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         w = FIXED ? 1'b1 : i[0];
         if (w) q1.push_back(32'hA500_0020);
         else   q0.push_back(32'hA500_0010);
         @(negedge clk);
         chk("arb_m0_wait", m0_waitrequest, w);
         chk("arb_m1_wait", m1_waitrequest, !w);
         next();
      end
      idle_all();
      next();

      // Byte lanes at the top word.
      m1_set(1'b0, 1'b1, 10'h3FF, 4'hF, 32'h1122_3344, 1'b0);
      next();
      m1_set(1'b0, 1'b1, 10'h3FF, 4'h2, 32'hAABB_CCDD, 1'b0);
      next();
      m1_set(1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0, 1'b0);
      q1.push_back(32'h1122_CC44);
      @(negedge clk);
      chk("be_m1_wait", m1_waitrequest, 0);
      chk("be_addr", mem_address, 10'h3FF);
      next();
      idle_all();
      next();

      // Lock held across accesses, released by an access with lock=0.
      m1_set(1'b0, 1'b1, 10'h100, 4'hF, 32'h1, 1'b1);
      @(negedge clk);
      chk("lk_first_m1_wait", m1_waitrequest, 0);
      next();
      for (int j = 0; j < 4; j++) begin
         m1_set(1'b0, 1'b1, 10'h101 + 10'(j), 4'hF, 32'(j), j < 3);
         m0_set(1'b1, 1'b0, 10'h010, 4'hF, 32'h0, 1'b0);
         @(negedge clk);
         chk("lk_m0_wait", m0_waitrequest, 1);
         chk("lk_m1_wait", m1_waitrequest, 0);
         next();
      end
      m1_set(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
      q0.push_back(32'hA500_0010);
      @(negedge clk);
      chk("lk_release_m0_wait", m0_waitrequest, 0);
      next();
      idle_all();
      next();

      // Lock released by 16 idle cycles of the owner.
      m1_set(1'b0, 1'b1, 10'h105, 4'hF, 32'h5, 1'b1);
      next();
      m1_set(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
      m0_set(1'b1, 1'b0, 10'h020, 4'hF, 32'h0, 1'b0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("to_m0_wait", m0_waitrequest, 1);
         next();
      end
      q0.push_back(32'hA500_0020);
      @(negedge clk);
      chk("to_release_m0_wait", m0_waitrequest, 0);
      next();
      idle_all();
      next();

      // Memory gate right after an accepted read.
      m0_set(1'b1, 1'b0, 10'h005, 4'hF, 32'h0, 1'b0);
      q0.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      chk("gate_rd_m0_wait", m0_waitrequest, 0);
      next();
      mem_reset_req = 1'b1;
      m0_set(1'b1, 1'b0, 10'h010, 4'hF, 32'h0, 1'b0);
      m1_set(1'b1, 1'b0, 10'h020, 4'hF, 32'h0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         if (k == 0) begin
            @(negedge clk);
            chk("gate_rdv", m0_readdatavalid, 1);
         end else begin
            @(negedge clk);
         end
         chk("gate_m0_wait", m0_waitrequest, 1);
         chk("gate_m1_wait", m1_waitrequest, 1);
         chk("gate_clken", mem_clken, 0);
         chk("gate_cs", mem_chipselect, 0);
         next();
      end
      mem_reset_req = 1'b0;
      m1_set(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0);
      q0.push_back(32'hA500_0010);
      @(negedge clk);
      chk("gate_resume_wait", m0_waitrequest, 0);
      chk("gate_resume_clken", mem_clken, 1);
      next();
      idle_all();
      next();

      // Reset the cycle after a read is accepted: that read never returns.
      m0_set(1'b1, 1'b0, 10'h005, 4'hF, 32'h0, 1'b0);
      @(negedge clk);
      chk("rr_m0_wait", m0_waitrequest, 0);
      next();
      reset_n = 1'b0;
      idle_all();
      @(negedge clk);
      chk("rst_mid_rdv", m0_readdatavalid, 0);
      next();
      next();
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_after_rdv", m0_readdatavalid, 0);
      next();

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/uart_mem_arbiter.md
# uart_mem_arbiter

Two-port arbiter sharing the 1024×32 single-port on-chip memory of the UART subsystem between a host-side Avalon-MM master (port 0, CPU) and the UART receive/transmit buffer engine (port 1). It accepts one access per cycle, grants it round-robin with optional lock, drives the memory's single port, and routes each read result back to the master that issued it.

## Interface
Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active low
- mN_address  in  ADDR_W  word address from master N (N = 0, 1)
- mN_byteenable  in  4  byte lanes for master N writes
- mN_read  in  1  read request from master N
- mN_write  in  1  write request from master N
- mN_writedata  in  32  write data from master N
- mN_lock  in  1  hold the grant after this access
- mN_waitrequest  out  1  request not accepted this cycle
- mN_readdata  out  32  read data to master N
- mN_readdatavalid  out  1  mN_readdata valid this cycle
- mem_reset_req  in  1  memory clock-enable gate request from the system
- mem_address  out  ADDR_W  to memory address
- mem_byteenable  out  4  to memory byteenable
- mem_chipselect  out  1  to memory chipselect
- mem_write  out  1  to memory write
- mem_writedata  out  32  to memory writedata
- mem_clken  out  1  to memory clken
- mem_readdata  in  32  from memory; valid the cycle after the read is issued

## Operation
- Request from master N: mN_read | mN_write. If both are set, write wins and the read is dropped.
- Arbitration, combinational from the current requests and the registered state:
  - Locked state: if lock_owner is valid, only that master can win. The other master sees waitrequest=1.
  - Both requesting: the master not in last_grant wins.
  - One requesting: that master wins.
- Winner: mN_waitrequest=0, and the memory port is driven from that master with mem_chipselect=1. Loser, or any master while blocked: mN_waitrequest=1.
- No winner: mem_chipselect=0, mem_write=0. Address, byteenable and writedata hold their last values.
- last_grant updates to the winner on every accepted access.
- Lock:
  - lock_owner is set to N when N's accepted access has mN_lock=1.
  - lock_owner clears when N's accepted access has mN_lock=0.
  - lock_owner also clears when N presents no request for 16 consecutive cycles. A 4-bit idle counter counts these cycles and resets on every accepted access.
- Read return: an accepted read sets rd_pend=1 and rd_tag=N.
  - Next cycle: mN_readdatavalid=1 and mN_readdata=mem_readdata for N=rd_tag.
  - The other master's readdatavalid=0. Both readdata outputs carry mem_readdata regardless.
  - Back-to-back reads alternate tags correctly.
- mem_reset_req=1 blocks all masters: both waitrequest=1, mem_clken=0.
  - An already issued read still returns its readdatavalid the next cycle. The memory output is unregistered, so q holds during the gate.
- mem_clken=1 otherwise.
- Reset values (reset_n=0 at a clk edge):
  - last_grant=1, so port 0 wins the first tie.
  - lock_owner invalid, idle counter 0, rd_pend=0.
  - While reset_n=0, all outputs are forced: waitrequest=1, readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
- A pending read at reset is discarded; no readdatavalid is issued.

## Timing
- Accept to memory: same cycle (combinational grant). The memory registers the address and data at the next clk edge.
- Read latency: readdatavalid exactly 1 cycle after the accepting cycle.
- Write: complete at the accepting clk edge. A read of the same address the next cycle returns the new data.
- Throughput: 1 access per cycle, with no dead cycle between masters.
- Fairness: with both masters continuously requesting and not locked, grants strictly alternate 0,1,0,1.

## Configuration
- UART_MEM_ARB_FIXED_PRIO_EN defined: round-robin is replaced by fixed priority.
  - Port 1 (UART engine) wins every tie.
  - last_grant is not used for arbitration.
  - Lock still overrides priority.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Reset then single access: release reset_n, m0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then reads 0x005. Required: m0_waitrequest=0 both cycles, m0_readdatavalid=1 with 0xDEADBEEF one cycle after the read, m1_readdatavalid=0.
- Contention, round-robin: both masters read continuously from addresses 0x010 (m0) and 0x020 (m1). Required: first grant to m0, then strict alternation, and each readdatavalid tagged to the correct master with its own address's data.
- Byte lanes: m1 writes 0x11223344 to 0x3FF, then writes 0xAABBCCDD with byteenable 0x2. Required: a subsequent read returns 0x1122CC44, and address 0x3FF is accessible with no wrap fault.
- Lock and timeout:
  - m1 writes with m1_lock=1, then makes 3 locked accesses while m0 requests. Required: m0 stalled the whole time, then granted the cycle after m1's access with lock=0.
  - Repeat with m1 going idle instead. Required: lock releases after 16 idle cycles.
- Memory gate: assert mem_reset_req for 5 cycles the cycle after an m0 read is accepted. Required: readdatavalid still arrives the next cycle, both waitrequest=1 and mem_clken=0 for 5 cycles, then normal operation resumes.
- Reset mid-read and fixed priority:
  - Drop reset_n the cycle after a read is accepted. Required: no readdatavalid.
  - With UART_MEM_ARB_FIXED_PRIO_EN defined and both masters requesting, m1 wins every cycle.
